// File: rtl/la_cmd_pkg.sv
// Shared types and constants for the LogicAnalyzer2 host-command engine:
// the packetizer FSM state encoding and the kernel opcode map.
package la_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] OP_START          = 8'h01;
  localparam logic [7:0] OP_ABORT          = 8'h02;
  localparam logic [7:0] OP_WR_TRIG_CFG    = 8'h03;
  localparam logic [7:0] OP_WR_BUFF_CFG    = 8'h04;
  localparam logic [7:0] OP_RD_TRACE_DATA  = 8'h05;
  localparam logic [7:0] OP_RD_TRACE_SIZE  = 8'h06;
  localparam logic [7:0] OP_RD_TRIG_SAMPLE = 8'h07;
  localparam logic [7:0] OP_RESET_LOGCAP   = 8'h09;
  localparam logic [7:0] OP_RD_BUFF_CFG    = 8'h0A;
  localparam logic [7:0] OP_RD_TRIG_CFG    = 8'h0B;

endpackage

// File: rtl/uart_fifo_strobe.sv
// One-shot strobe for the uart_tx6/uart_rx6 buffer handshakes. A request
// produces a single-cycle registered pulse; the cycle after a pulse is always
// a gap so the FIFO's full/present flag can settle before the next access.
module uart_fifo_strobe
  import la_cmd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic fire,
  output logic pulse
);

  logic pulse_reg;

  // A request is honoured only when no pulse is currently on the wire.
  assign fire  = req && !pulse_reg;
  assign pulse = pulse_reg;

  // Register the strobe so the FIFO sees a clean one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pulse_reg <= 1'b0;
    else       pulse_reg <= fire;
  end

endmodule

// File: rtl/uart_cmd_packetizer.sv
// Host-command engine: serialises opcode + payload into the UART tx buffer
// under backpressure, then gathers a response of programmable length from
// the rx buffer with an inter-byte timeout. Stray rx bytes in IDLE are
// drained and discarded.
module uart_cmd_packetizer
  import la_cmd_pkg::*;
#(
  parameter  int PAYLOAD_BYTES  = 8,
  parameter  int RSP_MAX_BYTES  = 8,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int LW = $clog2(((PAYLOAD_BYTES > RSP_MAX_BYTES) ? PAYLOAD_BYTES : RSP_MAX_BYTES) + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_opcode,
  input  logic [PAYLOAD_BYTES*8-1:0] cmd_payload,
  input  logic [LW-1:0]              cmd_len,
  input  logic [LW-1:0]              rsp_len,
  output logic [7:0]                 tx_data,
  output logic                       tx_write,
  input  logic                       tx_full,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_present,
  output logic                       rx_read,
  output logic                       rsp_valid,
  output logic                       rsp_timeout,
  output logic [LW-1:0]              rsp_count,
  output logic [RSP_MAX_BYTES*8-1:0] rsp_data,
  output logic                       stray_drop
);

  // The byte index spans opcode plus payload, so it needs one bit more than LW.
  localparam int              IW      = LW + 1;
  localparam int              NB      = 2 ** IW;
  localparam int              TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [LW-1:0]   PAY_MAX = LW'(PAYLOAD_BYTES);
  localparam logic [LW-1:0]   RSP_MAX = LW'(RSP_MAX_BYTES);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                     state_reg, state_next;
  logic [7:0]                 opcode_reg;
  logic [PAYLOAD_BYTES*8-1:0] payload_reg;
  logic [LW-1:0]              cmd_len_reg, rsp_len_reg, rsp_count_reg;
  logic [IW-1:0]              idx_reg;
  logic [TW-1:0]              to_cnt_reg;
  logic                       timeout_flag_reg;
  logic [7:0]                 tx_data_reg;
  logic [7:0]                 rsp_bytes_reg [RSP_MAX_BYTES];
  logic [7:0]                 cmd_bytes [NB];

  logic tx_req, tx_fire, tx_pulse;
  logic rx_req, rx_fire, rx_pulse;
  logic accept, all_issued, capture, timeout_hit;

  // Flatten the latched command into a byte table: opcode first, then
  // payload bytes; slots past the payload read as zero.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_cmd_bytes
      if (gi == 0) begin : g_op
        assign cmd_bytes[gi] = opcode_reg;
      end else if (gi <= PAYLOAD_BYTES) begin : g_pl
        assign cmd_bytes[gi] = payload_reg[8*(gi-1) +: 8];
      end else begin : g_pad
        assign cmd_bytes[gi] = 8'h00;
      end
    end
    for (genvar gi = 0; gi < RSP_MAX_BYTES; gi++) begin : g_rsp_pack
      assign rsp_data[8*gi +: 8] = rsp_bytes_reg[gi];
    end
  endgenerate

  assign accept     = (state_reg == IDLE) && cmd_valid;
  assign all_issued = (idx_reg == ({1'b0, cmd_len_reg} + IW'(1)));
  assign capture    = (state_reg == WAIT_RSP) && rx_pulse;
  // Expiry yields to a read being launched or completed this cycle.
  assign timeout_hit = (state_reg == WAIT_RSP) && !rx_pulse && !rx_fire &&
                       (rsp_count_reg != rsp_len_reg) && (to_cnt_reg == TO_LAST);

  uart_fifo_strobe u_tx_strobe (
    .clk   (clk),
    .reset (reset),
    .req   (tx_req),
    .fire  (tx_fire),
    .pulse (tx_pulse)
  );

  uart_fifo_strobe u_rx_strobe (
    .clk   (clk),
    .reset (reset),
    .req   (rx_req),
    .fire  (rx_fire),
    .pulse (rx_pulse)
  );

  assign tx_write  = tx_pulse;
  assign tx_data   = tx_data_reg;
  assign rx_read   = rx_pulse;
  assign rsp_count = rsp_count_reg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: leave SEND only once the last byte's write pulse is out.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (cmd_valid) state_next = SEND;
      SEND:     if (tx_pulse && all_issued)
                  state_next = (rsp_len_reg == '0) ? DONE : WAIT_RSP;
      WAIT_RSP: if (!rx_pulse && (rsp_count_reg == rsp_len_reg)) state_next = DONE;
                else if (timeout_hit)                            state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs and strobe requests per state; IDLE holds off draining on the
  // accept cycle so no read can spill into SEND.
  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    stray_drop  = 1'b0;
    tx_req      = 1'b0;
    rx_req      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready  = 1'b1;
        rx_req     = rx_present && !cmd_valid;
        stray_drop = rx_pulse;
      end
      SEND:     tx_req = !tx_full && !all_issued;
      WAIT_RSP: rx_req = rx_present && (rsp_count_reg != rsp_len_reg);
      DONE: begin
        rsp_valid   = 1'b1;
        rsp_timeout = timeout_flag_reg;
      end
      default: ;
    endcase
  end

  // Command latch, tx byte sequencing, response count and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_reg       <= '0;
      payload_reg      <= '0;
      cmd_len_reg      <= '0;
      rsp_len_reg      <= '0;
      idx_reg          <= '0;
      rsp_count_reg    <= '0;
      timeout_flag_reg <= 1'b0;
      tx_data_reg      <= '0;
      to_cnt_reg       <= '0;
    end else begin
      if (accept) begin
        opcode_reg       <= cmd_opcode;
        payload_reg      <= cmd_payload;
        cmd_len_reg      <= (cmd_len > PAY_MAX) ? PAY_MAX : cmd_len;
        rsp_len_reg      <= (rsp_len > RSP_MAX) ? RSP_MAX : rsp_len;
        idx_reg          <= '0;
        rsp_count_reg    <= '0;
        timeout_flag_reg <= 1'b0;
      end
      if (tx_fire) begin
        tx_data_reg <= cmd_bytes[idx_reg];
        idx_reg     <= idx_reg + IW'(1);
      end
      if (capture)     rsp_count_reg    <= rsp_count_reg + LW'(1);
      if (timeout_hit) timeout_flag_reg <= 1'b1;
      if ((state_reg != WAIT_RSP) || rx_pulse) to_cnt_reg <= '0;
      else                                     to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  // Response byte store: cleared on accept, written at the current count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RSP_MAX_BYTES; i++) rsp_bytes_reg[i] <= '0;
    end else begin
      for (int i = 0; i < RSP_MAX_BYTES; i++) begin
        if (accept)                                        rsp_bytes_reg[i] <= '0;
        else if (capture && (rsp_count_reg == LW'(i)))     rsp_bytes_reg[i] <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_packetizer.sv
// Self-checking bench for uart_cmd_packetizer with a queue-based UART FIFO
// model and a byte-list reference model of command and response framing.
module tb_uart_cmd_packetizer;
  import la_cmd_pkg::*;

  localparam int PB = 8;
  localparam int RB = 8;
  localparam int TO = 100;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [7:0]      cmd_opcode = '0;
  logic [PB*8-1:0] cmd_payload = '0;
  logic [LW-1:0]   cmd_len = '0;
  logic [LW-1:0]   rsp_len = '0;
  logic [7:0]      tx_data;
  logic            tx_write;
  logic            tx_full = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_present = 1'b0;
  logic            rx_read;
  logic            rsp_valid;
  logic            rsp_timeout;
  logic [LW-1:0]   rsp_count;
  logic [RB*8-1:0] rsp_data;
  logic            stray_drop;

  uart_cmd_packetizer #(
    .PAYLOAD_BYTES(PB), .RSP_MAX_BYTES(RB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_payload(cmd_payload), .cmd_len(cmd_len),
    .rsp_len(rsp_len), .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .rx_data(rx_data), .rx_present(rx_present), .rx_read(rx_read),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_count(rsp_count),
    .rsp_data(rsp_data), .stray_drop(stray_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ops [10] = '{OP_START, OP_ABORT, OP_WR_TRIG_CFG, OP_WR_BUFF_CFG,
                           OP_RD_TRACE_DATA, OP_RD_TRACE_SIZE, OP_RD_TRIG_SAMPLE,
                           OP_RESET_LOGCAP, OP_RD_BUFF_CFG, OP_RD_TRIG_CFG};

  // rx FIFO model: pops on the DUT's read strobe, pushes from the stimulus.
  logic [7:0] rxq [$];
  logic       push_en = 1'b0;
  logic [7:0] push_byte = '0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rx_read && rxq.size() > 0) void'(rxq.pop_front());
    if (push_en) rxq.push_back(push_byte);
    rx_present <= (rxq.size() != 0);
    rx_data    <= (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Monitor, sampled mid-cycle.
  logic [7:0]    tx_log [$];
  int            tx_cyc [$];
  int            rx_reads = 0, last_rx_cyc = 0, strays = 0, ready_low = 0;
  int            rsp_events = 0, last_rsp_cyc = 0;
  int            tx_gap_err = 0, rx_gap_err = 0, tx_stall_err = 0;
  logic [RB*8-1:0] last_data = '0;
  logic [LW-1:0] last_count = '0;
  logic          last_to = 1'b0;
  logic          prev_txw = 1'b0, prev_rxr = 1'b0, prev_full = 1'b0;

  always @(negedge clk) begin
    if (tx_write) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
      if (prev_txw)  tx_gap_err++;
      if (prev_full) tx_stall_err++;
    end
    if (rx_read) begin
      rx_reads++;
      last_rx_cyc = cyc;
      if (prev_rxr) rx_gap_err++;
    end
    if (stray_drop) strays++;
    if (!cmd_ready) ready_low++;
    if (rsp_valid) begin
      rsp_events++;
      last_rsp_cyc = cyc;
      last_data    = rsp_data;
      last_count   = rsp_count;
      last_to      = rsp_timeout;
    end
    prev_txw  = tx_write;
    prev_rxr  = rx_read;
    prev_full = tx_full;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b, input int gap);
    push_byte = b;
    push_en   = 1'b1;
    tick();
    push_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [PB*8-1:0] pl,
                          input logic [LW-1:0] cl, input logic [LW-1:0] rl);
    int n = 0;
    while (!cmd_ready && n < 1000) begin tick(); n++; end
    n_vec++;
    if (!cmd_ready) begin
      n_err++;
      $display("FAIL send_ready: cmd_ready=%0b after %0d cycles, need 1", cmd_ready, n);
    end
    cmd_opcode = op; cmd_payload = pl; cmd_len = cl; rsp_len = rl;
    cmd_valid = 1'b1;
    tick();
    cmd_valid   = 1'b0;
    cmd_opcode  = 8'($urandom);
    cmd_payload = {$urandom, $urandom};
    cmd_len     = LW'($urandom);
    rsp_len     = LW'($urandom);
  endtask

  task automatic wait_rsp(input int snap, input int budget, input string name);
    int n = 0;
    while (rsp_events == snap && n < budget) begin tick(); n++; end
    n_vec++;
    if (rsp_events == snap) begin
      n_err++;
      $display("FAIL %s_rsp: got no rsp_valid in %0d cycles, need one", name, budget);
    end
  endtask

  task automatic wait_tx(input int base, input int cnt, input int budget);
    int n = 0;
    while (tx_log.size() - base < cnt && n < budget) begin tick(); n++; end
    n_vec++;
    if (tx_log.size() - base < cnt) begin
      n_err++;
      $display("FAIL wait_tx: got %0d writes, need %0d", tx_log.size() - base, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_vec++; if (cmd_ready !== 1'b1)  begin n_err++; $display("FAIL rst_cmd_ready: got %b need 1", cmd_ready); end
    n_vec++; if (tx_write !== 1'b0)   begin n_err++; $display("FAIL rst_tx_write: got %b need 0", tx_write); end
    n_vec++; if (tx_data !== 8'h00)   begin n_err++; $display("FAIL rst_tx_data: got %h need 00", tx_data); end
    n_vec++; if (rx_read !== 1'b0)    begin n_err++; $display("FAIL rst_rx_read: got %b need 0", rx_read); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin n_err++; $display("FAIL rst_rsp_flags: got %b%b need 00", rsp_valid, rsp_timeout); end
    n_vec++; if (rsp_count !== '0)    begin n_err++; $display("FAIL rst_rsp_count: got %0d need 0", rsp_count); end
    n_vec++; if (rsp_data !== '0)     begin n_err++; $display("FAIL rst_rsp_data: got %h need 0", rsp_data); end
    n_vec++; if (stray_drop !== 1'b0) begin n_err++; $display("FAIL rst_stray: got %b need 0", stray_drop); end
    $display("reset: released");
  endtask

  task automatic test_write_cfg();
    logic [7:0] exp [$];
    int base = tx_log.size();
    int snap = rsp_events;
    exp.push_back(8'h03); exp.push_back(8'h55);
    for (int i = 0; i < 7; i++) exp.push_back(8'h00);
    send_cmd(8'h03, 64'h55, LW'(8), LW'(0));
    wait_rsp(snap, 200, "wrcfg");
    n_vec++;
    if (tx_log.size() - base != 9) begin n_err++; $display("FAIL wrcfg_count: got %0d writes need 9", tx_log.size() - base); end
    for (int i = 0; i < 9 && base + i < tx_log.size(); i++) begin
      n_vec++;
      if (tx_log[base+i] !== exp[i]) begin n_err++; $display("FAIL wrcfg_byte%0d: got %h need %h", i, tx_log[base+i], exp[i]); end
      if (i > 0) begin
        n_vec++;
        if (tx_cyc[base+i] - tx_cyc[base+i-1] != 2) begin n_err++; $display("FAIL wrcfg_spacing%0d: got %0d cycles need 2", i, tx_cyc[base+i] - tx_cyc[base+i-1]); end
      end
    end
    n_vec++; if (last_count !== 4'd0 || last_to !== 1'b0) begin n_err++; $display("FAIL wrcfg_rsp: got count %0d to %b need 0 0", last_count, last_to); end
    $display("wr_trig_cfg: %0d bytes sent", tx_log.size() - base);
  endtask

  task automatic test_read_cfg();
    int base = tx_log.size();
    int snap = rsp_events;
    int rx0 = rx_reads, st0 = strays;
    send_cmd(8'h0B, '0, LW'(0), LW'(8));
    push_rx(8'h55, 0);
    for (int i = 0; i < 7; i++) push_rx(8'h00, 0);
    wait_rsp(snap, 300, "rdcfg");
    n_vec++; if (tx_log.size() - base != 1) begin n_err++; $display("FAIL rdcfg_txcount: got %0d need 1", tx_log.size() - base); end
    else begin n_vec++; if (tx_log[base] !== 8'h0B) begin n_err++; $display("FAIL rdcfg_op: got %h need 0b", tx_log[base]); end end
    n_vec++; if (rx_reads - rx0 != 8) begin n_err++; $display("FAIL rdcfg_reads: got %0d need 8", rx_reads - rx0); end
    n_vec++; if (last_data !== 64'h55) begin n_err++; $display("FAIL rdcfg_data: got %h need 55", last_data); end
    n_vec++; if (last_count !== 4'd8 || last_to !== 1'b0) begin n_err++; $display("FAIL rdcfg_rsp: got count %0d to %b need 8 0", last_count, last_to); end
    n_vec++; if (strays != st0) begin n_err++; $display("FAIL rdcfg_strays: got %0d need 0", strays - st0); end
    $display("rd_trig_cfg: response %h count %0d", last_data, last_count);
  endtask

  task automatic test_stall();
    logic [7:0] exp [$];
    logic [PB*8-1:0] pl = {$urandom, $urandom};
    int base = tx_log.size();
    int snap = rsp_events;
    int wb;
    exp.push_back(8'h04);
    for (int i = 0; i < 8; i++) exp.push_back(pl[8*i +: 8]);
    send_cmd(8'h04, pl, LW'(8), LW'(0));
    wait_tx(base, 3, 100);
    tx_full = 1'b1;
    wb = tx_log.size();
    repeat (50) tick();
    n_vec++; if (tx_log.size() != wb) begin n_err++; $display("FAIL stall_quiet: got %0d writes during stall need 0", tx_log.size() - wb); end
    tx_full = 1'b0;
    wait_rsp(snap, 200, "stall");
    n_vec++; if (tx_log.size() - base != 9) begin n_err++; $display("FAIL stall_count: got %0d writes need 9", tx_log.size() - base); end
    for (int i = 0; i < 9 && base + i < tx_log.size(); i++) begin
      n_vec++;
      if (tx_log[base+i] !== exp[i]) begin n_err++; $display("FAIL stall_byte%0d: got %h need %h", i, tx_log[base+i], exp[i]); end
    end
    $display("stall: payload %h sent across 50-cycle stall", pl);
  endtask

  task automatic test_timeout();
    int snap = rsp_events;
    int lat;
    send_cmd(8'h07, {$urandom, $urandom}, LW'(0), LW'(4));
    push_rx(8'hA1, 1);
    push_rx(8'h5C, 1);
    wait_rsp(snap, 400, "timeout");
    lat = last_rsp_cyc - last_rx_cyc;
    n_vec++; if (last_to !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b need 1", last_to); end
    n_vec++; if (last_count !== 4'd2) begin n_err++; $display("FAIL to_count: got %0d need 2", last_count); end
    n_vec++; if (last_data !== 64'h5CA1) begin n_err++; $display("FAIL to_data: got %h need 5ca1", last_data); end
    n_vec++; if (lat < 95 || lat > 106) begin n_err++; $display("FAIL to_latency: got %0d cycles need about %0d", lat, TO); end
    $display("timeout: flagged after %0d cycles with %0d bytes", lat, last_count);
  endtask

  task automatic test_stray();
    int st0 = strays, rl0 = ready_low, ev0 = rsp_events, rx0 = rx_reads;
    for (int i = 0; i < 3; i++) push_rx(8'($urandom), 2);
    repeat (10) tick();
    n_vec++; if (strays - st0 != 3) begin n_err++; $display("FAIL stray_count: got %0d need 3", strays - st0); end
    n_vec++; if (rx_reads - rx0 != 3) begin n_err++; $display("FAIL stray_reads: got %0d need 3", rx_reads - rx0); end
    n_vec++; if (rsp_data !== 64'h5CA1 || rsp_count !== 4'd2) begin n_err++; $display("FAIL stray_hold: got %h/%0d need 5ca1/2", rsp_data, rsp_count); end
    n_vec++; if (ready_low != rl0) begin n_err++; $display("FAIL stray_ready: got %0d low cycles need 0", ready_low - rl0); end
    n_vec++; if (rsp_events != ev0) begin n_err++; $display("FAIL stray_rsp: got %0d rsp_valid need 0", rsp_events - ev0); end
    $display("stray: %0d bytes dropped", strays - st0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    logic [PB*8-1:0] pl = {$urandom, $urandom};
    int base = tx_log.size();
    int ev0, wb, snap;
    send_cmd(8'h03, {$urandom, $urandom}, LW'(8), LW'(4));
    wait_tx(base, 3, 100);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_vec++; if (tx_write !== 1'b0) begin n_err++; $display("FAIL rmid_tx_write: got %b need 0", tx_write); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data: got %h need 00", tx_data); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b need 1", cmd_ready); end
    n_vec++; if (rx_read !== 1'b0 || rsp_count !== '0 || rsp_data !== '0) begin n_err++; $display("FAIL rmid_rsp: got rd %b count %0d data %h need 0", rx_read, rsp_count, rsp_data); end
    ev0 = rsp_events;
    tick(); tick();
    reset = 1'b0;
    wb = tx_log.size();
    repeat (20) tick();
    n_vec++; if (rsp_events != ev0) begin n_err++; $display("FAIL rmid_no_rsp: got %0d rsp_valid need 0", rsp_events - ev0); end
    n_vec++; if (tx_log.size() != wb) begin n_err++; $display("FAIL rmid_no_tx: got %0d writes need 0", tx_log.size() - wb); end
    base = tx_log.size();
    snap = rsp_events;
    exp.push_back(8'h09);
    for (int i = 0; i < 5; i++) exp.push_back(pl[8*i +: 8]);
    send_cmd(8'h09, pl, LW'(5), LW'(0));
    wait_rsp(snap, 200, "rmid_after");
    n_vec++; if (tx_log.size() - base != 6) begin n_err++; $display("FAIL rmid_after_count: got %0d need 6", tx_log.size() - base); end
    for (int i = 0; i < 6 && base + i < tx_log.size(); i++) begin
      n_vec++;
      if (tx_log[base+i] !== exp[i]) begin n_err++; $display("FAIL rmid_after_byte%0d: got %h need %h", i, tx_log[base+i], exp[i]); end
    end
    $display("reset_mid: abandoned command, recovery command sent %0d bytes", tx_log.size() - base);
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [7:0] op = ops[$urandom_range(0, 9)];
      logic [PB*8-1:0] pl = {$urandom, $urandom};
      int cl = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      int rl = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      int cle = (cl > PB) ? PB : cl;
      int rle = (rl > RB) ? RB : rl;
      int k = (rle == 0) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(0, rle - 1) : rle);
      logic [7:0] exp_tx [$];
      logic [7:0] rbytes [$];
      logic [RB*8-1:0] exp_data = '0;
      int base = tx_log.size();
      int snap = rsp_events;
      int st0 = strays;
      exp_tx.push_back(op);
      for (int i = 0; i < cle; i++) exp_tx.push_back(pl[8*i +: 8]);
      for (int i = 0; i < k; i++) begin
        rbytes.push_back(8'($urandom));
        exp_data[8*i +: 8] = rbytes[i];
      end
      send_cmd(op, pl, LW'(cl), LW'(rl));
      fork
        begin
          repeat (60) begin tx_full = ($urandom_range(0, 3) == 0); tick(); end
          tx_full = 1'b0;
        end
        begin
          for (int i = 0; i < k; i++) push_rx(rbytes[i], $urandom_range(0, 5));
        end
      join
      wait_rsp(snap, 600, "rand");
      repeat (3) tick();
      n_vec++; if (tx_log.size() - base != cle + 1) begin n_err++; $display("FAIL rand%0d_txcount: got %0d need %0d", it, tx_log.size() - base, cle + 1); end
      for (int i = 0; i <= cle && base + i < tx_log.size(); i++) begin
        n_vec++;
        if (tx_log[base+i] !== exp_tx[i]) begin n_err++; $display("FAIL rand%0d_byte%0d: got %h need %h", it, i, tx_log[base+i], exp_tx[i]); end
      end
      n_vec++; if (rsp_events - snap != 1) begin n_err++; $display("FAIL rand%0d_events: got %0d rsp_valid need 1", it, rsp_events - snap); end
      n_vec++; if (last_count !== LW'(k)) begin n_err++; $display("FAIL rand%0d_count: got %0d need %0d", it, last_count, k); end
      n_vec++; if (last_to !== (k < rle)) begin n_err++; $display("FAIL rand%0d_timeout: got %b need %b", it, last_to, (k < rle)); end
      n_vec++; if (last_data !== exp_data) begin n_err++; $display("FAIL rand%0d_data: got %h need %h", it, last_data, exp_data); end
      n_vec++; if (strays != st0) begin n_err++; $display("FAIL rand%0d_strays: got %0d need 0", it, strays - st0); end
      $display("rand %0d: op %h len %0d/%0d rsp_len %0d/%0d got %0d bytes timeout %b",
               it, op, cl, cle, rl, rle, last_count, last_to);
    end
  endtask

  task automatic test_handshake_rules();
    n_vec++; if (tx_gap_err != 0)   begin n_err++; $display("FAIL tx_gap: got %0d back-to-back writes need 0", tx_gap_err); end
    n_vec++; if (rx_gap_err != 0)   begin n_err++; $display("FAIL rx_gap: got %0d back-to-back reads need 0", rx_gap_err); end
    n_vec++; if (tx_stall_err != 0) begin n_err++; $display("FAIL tx_full_rule: got %0d writes after full need 0", tx_stall_err); end
  endtask

  initial begin
    test_reset();
    test_write_cfg();
    test_read_cfg();
    test_stall();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random(24);
    test_handshake_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
